// File: rtl/store_drain_unit.sv
// Store queue drain: pops released entries, splits FP doubles into two
// 32-bit write beats and tracks outstanding write credit.
module store_drain_unit #(
    parameter int FLEN            = 64,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sq_valid,
    input  logic            sq_empty,
    input  logic [31:0]     sq_addr,
    input  logic [3:0]      sq_be,
    input  logic            sq_cache_op,
    input  logic [31:0]     sq_data,
    input  logic            sq_fp,
    input  logic            sq_double,
    input  logic [FLEN-1:0] sq_fp_data,
    output logic            sq_pop,
    output logic            mem_req,
    input  logic            mem_ack,
    output logic [31:0]     mem_addr,
    output logic [3:0]      mem_be,
    output logic [31:0]     mem_wdata,
    output logic            mem_cache_op,
    input  logic            mem_wr_done,
    output logic [CW-1:0]   outstanding,
    output logic            drained
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ISSUE_HI
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          cop_q, cop_d;
    logic          hi_pend_q, hi_pend_d;
    logic [31:0]   hi_data_q, hi_data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [63:0]   fp_ext;
    logic          is_dbl;
    logic          accept;
    logic          capture;

    always_comb begin
        fp_ext = 64'(sq_fp_data);
        // Cache ops never split, even if the double flag is set.
        is_dbl = (FLEN == 64) && sq_fp && sq_double && !sq_cache_op;

        mem_req = (state_q != IDLE) && (cnt_q < CW'(MAX_OUTSTANDING));
        accept  = mem_req && mem_ack;
        capture = sq_valid && ((state_q == IDLE) ||
                  ((state_q == ISSUE) && accept && !hi_pend_q));
        sq_pop  = capture;

        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        cop_d     = cop_q;
        hi_pend_d = hi_pend_q;
        hi_data_d = hi_data_q;

        case (state_q)
            IDLE: ;
            ISSUE: begin
                if (accept) begin
                    if (hi_pend_q) begin
                        state_d   = ISSUE_HI;
                        addr_d    = {addr_q[31:3], 3'b100};
                        be_d      = 4'hF;
                        wdata_d   = hi_data_q;
                        hi_pend_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ISSUE_HI: begin
                if (accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            state_d   = ISSUE;
            cop_d     = sq_cache_op;
            hi_pend_d = is_dbl;
            hi_data_d = fp_ext[63:32];
            if (is_dbl) begin
                addr_d  = {sq_addr[31:3], 3'b000};
                be_d    = 4'hF;
                wdata_d = fp_ext[31:0];
            end else begin
                addr_d  = sq_addr;
                be_d    = sq_be;
                wdata_d = sq_data;
            end
        end

        cnt_d = cnt_q;
        if (accept && !mem_wr_done) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!accept && mem_wr_done && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            cop_q     <= 1'b0;
            hi_pend_q <= 1'b0;
            hi_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            cop_q     <= cop_d;
            hi_pend_q <= hi_pend_d;
            hi_data_q <= hi_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_be       = be_q;
    assign mem_wdata    = wdata_q;
    assign mem_cache_op = cop_q;
    assign outstanding  = cnt_q;
    assign drained      = (state_q == IDLE) && sq_empty && !sq_valid &&
                          (cnt_q == '0);

`ifndef SYNTHESIS
    a_done_underflow: assert property (@(posedge clk) disable iff (rst)
        mem_wr_done |-> (cnt_q != '0))
        else $error("mem_wr_done with nothing outstanding");
    a_ack_no_req: assert property (@(posedge clk) disable iff (rst)
        mem_ack |-> mem_req)
        else $error("mem_ack without mem_req");
`endif

endmodule

// File: doc/store_drain_unit.md
Name: store_drain_unit

Overview:
- Read-side consumer of the store queue: takes released entries off the queue head, pops them, and issues word-wide write requests to the data memory port.
- Splits FP double stores into two 32-bit beats.
- Tracks outstanding writes against a credit limit.
- Reports a `drained` status, which the fence/CSR logic uses to wait until all stores are globally performed.

Parameters:
- FLEN, 64, FP register width; legal values 32 or 64. At 32, double handling is disabled.
- MAX_OUTSTANDING, 4, maximum unacknowledged write beats (≥2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- sq_valid  in  1  queue head holds a released store
- sq_empty  in  1  store queue holds no entries
- sq_addr  in  32  store byte address
- sq_be  in  4  byte enables
- sq_cache_op  in  1  cache-management op flag
- sq_data  in  32  aligned integer/single data
- sq_fp  in  1  FP store
- sq_double  in  1  64-bit FP store
- sq_fp_data  in  FLEN  FP store data
- sq_pop  out  1  dequeue head (one-cycle pulse)
- mem_req  out  1  write request valid
- mem_ack  in  1  request accepted this cycle
- mem_addr  out  32  write address
- mem_be  out  4  byte enables
- mem_wdata  out  32  write data
- mem_cache_op  out  1  cache op flag
- mem_wr_done  in  1  one write beat completed
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  beats in flight
- drained  out  1  no stores queued, held, or in flight

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - sq_pop=0, mem_req=0, mem_addr/mem_be/mem_wdata/mem_cache_op=0, outstanding=0.
  - Held-entry registers cleared.
- FSM states: IDLE, ISSUE, ISSUE_HI.
- Capture condition: sq_valid & (state==IDLE | (state==ISSUE & mem_ack & ~beat_hi_pending)).
- On capture:
  - sq_pop=1 in the same cycle (combinational); the entry is latched on that clock edge.
  - Next state is ISSUE.
  - sq_pop is never asserted without sq_valid.
- Beat 0 fields:
  - Non-double: mem_addr=sq_addr, mem_be=sq_be, mem_wdata=sq_data.
  - Double (FLEN==64): mem_addr={sq_addr[31:3],3'b000}, mem_be=4'hF, mem_wdata=sq_fp_data[31:0].
  - Upper word sq_fp_data[63:32] is held for beat 1.
- mem_req = (state∈{ISSUE,ISSUE_HI}) & (outstanding < MAX_OUTSTANDING).
  - Outputs are stable while mem_req is high and mem_ack is low.
  - mem_req drops while credit is exhausted and reasserts once credit returns.
- ISSUE transitions, on mem_ack:
  - Double entry → ISSUE_HI: mem_addr={addr[31:3],3'b100}, mem_wdata=upper word, mem_be=4'hF.
  - Otherwise → capture of the next entry if sq_valid (back-to-back, one beat/cycle), else IDLE.
- ISSUE_HI transitions, on mem_ack → IDLE.
  - No capture in this cycle; the next entry is captured from IDLE the following cycle.
- Outstanding count:
  - outstanding_next = outstanding + (mem_req&mem_ack) − mem_wr_done.
  - A simultaneous accept and done leaves the count unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows.
  - Assertion errors: mem_wr_done while outstanding==0; mem_ack without mem_req.
- drained = (state==IDLE) & sq_empty & ~sq_valid & (outstanding==0), combinational. Value 1 after reset when the queue is empty.
- cache_op entries are issued as a single beat with mem_cache_op=1; the double split does not apply.
- Reset mid-transfer discards the held entry. Entries already popped are not replayed.

Test Plan:
- Single store, MAX_OUTSTANDING=4: sq_valid with addr 0x1000, be 4'b0011, data 0x0000BEEF; mem_ack tied 1.
  → sq_pop pulse cycle 0; mem_req cycle 1 with matching fields; outstanding=1; mem_wr_done in cycle 3 → outstanding=0, drained=1.
- Back-to-back: 3 entries, mem_ack=1.
  → pops in cycles 0, 1, 2; mem_req high in cycles 1–3 with addresses in order; outstanding reaches 3.
- Double: addr 0x2004, fp_data 0x11223344_55667788.
  → beat 0 addr 0x2000, wdata 0x55667788, be F; beat 1 addr 0x2004, wdata 0x11223344; exactly one sq_pop.
- Credit stall: MAX_OUTSTANDING=2, no mem_wr_done, 3 entries.
  → mem_req drops after 2 accepts with outstanding=2; one mem_wr_done → mem_req reasserts with the third entry's unchanged fields.
- Backpressure: mem_ack held 0 for 5 cycles.
  → mem_req and fields stable, no further sq_pop; the ack cycle advances.
- Async reset asserted in ISSUE_HI with outstanding=2.
  → all outputs 0 immediately (drained=1 if sq_empty); after release, the first sq_valid is captured normally.
